// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared definitions for the shift-engine family
//
// Purpose: FSM state encoding and default data width, used by the
//          left_shift and right_shift engines.
// Ports:   none (package)

package shift_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_t;

endpackage

// File: rtl/left_shift_engine.sv
// rtl/left_shift_engine.sv - multi-cycle left shifter, one bit position per clock
//
// Purpose: Accepts a word, a shift amount and a fill bit. It then shifts the
//          word left one position per cycle, inserting the fill bit at the
//          LSB. The result stays on dout/cout until the consumer accepts it.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   request present on din/amt/fill
//   in_ready   engine idle and able to accept a request
//   din        word to shift
//   amt        number of positions to shift (0..2^AW-1, may exceed WIDTH)
//   fill       bit inserted at the LSB on every step
//   out_valid  result available on dout/cout
//   out_ready  consumer accepts the result
//   dout       shifted word
//   cout       last bit shifted out of the MSB (0 when amt is 0)
//   busy       a request is in progress or its result is still pending

module left_shift_engine
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    amt,
    input  logic             fill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             cout,
    output logic             busy
);

    shift_state_t     state;
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             fill_reg;
    logic [AW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            data     <= '0;
            carry    <= 1'b0;
            fill_reg <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data     <= din;
                        fill_reg <= fill;
                        carry    <= 1'b0;
                        cnt      <= amt;
                        state    <= (amt == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    data  <= {data[WIDTH-2:0], fill_reg};
                    carry <= data[WIDTH-1];
                    // The counter saturates at zero. A zero count in SHIFT
                    // cannot be reached, but if it were, the engine finishes
                    // instead of wrapping.
                    if (cnt != '0) begin
                        cnt <= cnt - AW'(1);
                    end
                    if (cnt <= AW'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // All outputs are decoded from flops. dout/cout are not touched in IDLE
    // or DONE, so they hold the last result.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_SHIFT) || (state == ST_DONE);
    assign dout      = data;
    assign cout      = carry;

endmodule
